// File: rtl/bf16_pkg.sv
// Shared bfloat16 definitions: field widths, class codes and classifier.
// Used by the adder, the result collector and the future multiplier.
package bf16_pkg;

    localparam int BF16_EXP_W = 8;
    localparam int BF16_MAN_W = 7;
    localparam logic [BF16_EXP_W-1:0] BF16_EXP_MAX = 8'd255;

    typedef enum logic [2:0] {
        ZERO      = 3'd0,
        SUBNORMAL = 3'd1,
        NORMAL    = 3'd2,
        INF       = 3'd3,
        NAN       = 3'd4
    } bf16_class_t;

    // The sign bit does not affect the class.
    function automatic bf16_class_t bf16_classify(input logic [15:0] v);
        logic [BF16_EXP_W-1:0] e;
        logic [BF16_MAN_W-1:0] m;
        bf16_class_t           c;
        e = v[14:7];
        m = v[6:0];
        if (e == '0) begin
            c = (m == '0) ? ZERO : SUBNORMAL;
        end else if (e == BF16_EXP_MAX) begin
            c = (m == '0) ? INF : NAN;
        end else begin
            c = NORMAL;
        end
        return c;
    endfunction

endpackage

// File: rtl/bf16_sync_fifo.sv
// Single-clock FIFO with separate occupancy counter.
// Ports: push_i/wdata_i write side, pop_i/rdata_o read side (head shown
// combinationally), full_o/empty_o/count_o status. A push while full is
// accepted only when a pop happens in the same cycle.
module bf16_sync_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/bf16_result_collector.sv
// Captures each adder result on the rising edge of adder_ready, classifies
// it and buffers {class,sum} for a valid/ready consumer.
// Ports: adder_sum/adder_ready in; out_data/out_class/out_valid/out_ready
// stream; count occupancy; overflow/drop_count loss report, clear_overflow.
module bf16_result_collector
    import bf16_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              nreset,
    input  logic [15:0]       adder_sum,
    input  logic              adder_ready,
    output logic [15:0]       out_data,
    output logic [2:0]        out_class,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CW-1:0]     count,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count,
    input  logic              clear_overflow
);

    logic              ready_q;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic              drop;
    bf16_class_t       cls;
    logic [18:0]       head;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    // One push per adder_ready pulse regardless of its length.
    assign push = adder_ready & ~ready_q;
    assign cls  = bf16_classify(adder_sum);

    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;
    assign drop      = push & full & ~pop;

    assign out_class = head[18:16];
    assign out_data  = head[15:0];

    bf16_sync_fifo #(
        .WIDTH(19),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock   (clock),
        .nreset  (nreset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({cls, adder_sum}),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    // A drop in the same cycle as a clear leaves one recorded loss.
    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (clear_overflow) begin
                drop_cnt_d = DROP_W'(1);
            end else if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + DROP_W'(1);
            end
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            ready_q    <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            ready_q    <= adder_ready;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign overflow   = overflow_q;
    assign drop_count = drop_cnt_q;

endmodule
